// File: rtl/pointwise_modmul_pipe.sv
// Pipelined pointwise modular multiplier: out = (a*b) mod Q, 3 stages, valid/ready, frame index tracking.
// Optional sticky operand range check when PWM_RANGE_CHECK_EN is defined.
module pointwise_modmul_pipe #(
    parameter int unsigned      WIDTH = 16,
    parameter int unsigned      N     = 16,
    parameter logic [WIDTH-1:0] Q     = 16'h1e01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err_range
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [2*WIDTH-1:0] Q_WIDE = {{WIDTH{1'b0}}, Q};

    logic                 en;
    logic                 in_xfer;
    logic [2*WIDTH-1:0]   prod;

    logic                 s1_v_q, s1_v_d;
    logic [WIDTH-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDX_W-1:0]     s1_idx_q, s1_idx_d;
    logic                 s2_v_q, s2_v_d;
    logic [2*WIDTH-1:0]   s2_p_q, s2_p_d;
    logic [IDX_W-1:0]     s2_idx_q, s2_idx_d;
    logic                 s3_v_q, s3_v_d;
    logic [WIDTH-1:0]     s3_data_q, s3_data_d;
    logic [IDX_W-1:0]     s3_idx_q, s3_idx_d;
    logic [IDX_W-1:0]     in_cnt_q, in_cnt_d;

    // A single global enable: the whole pipe freezes while the output is held.
    assign en      = !(s3_v_q && !out_ready);
    assign in_xfer = in_valid && en;
    assign prod    = (2*WIDTH)'(s1_a_q) * (2*WIDTH)'(s1_b_q);

    always_comb begin
        // NOTE: every combinational output gets a hold default first so no path leaves it unassigned (no latch).
        s1_v_d    = s1_v_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_idx_d  = s1_idx_q;
        s2_v_d    = s2_v_q;
        s2_p_d    = s2_p_q;
        s2_idx_d  = s2_idx_q;
        s3_v_d    = s3_v_q;
        s3_data_d = s3_data_q;
        s3_idx_d  = s3_idx_q;
        in_cnt_d  = in_cnt_q;

        if (en) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_a_d   = in_a;
                s1_b_d   = in_b;
                s1_idx_d = in_cnt_q;
            end
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_p_d   = prod;
                s2_idx_d = s1_idx_q;
            end
            s3_v_d = s2_v_q;
            if (s2_v_q) begin
                s3_data_d = WIDTH'(s2_p_q % Q_WIDE);
                s3_idx_d  = s2_idx_q;
            end
        end

        // N is a power of two, so the natural wrap of the counter gives N-1 -> 0.
        if (in_xfer) begin
            in_cnt_d = in_cnt_q + IDX_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_idx_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_p_q    <= '0;
            s2_idx_q  <= '0;
            s3_v_q    <= 1'b0;
            s3_data_q <= '0;
            s3_idx_q  <= '0;
            in_cnt_q  <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_idx_q  <= s1_idx_d;
            s2_v_q    <= s2_v_d;
            s2_p_q    <= s2_p_d;
            s2_idx_q  <= s2_idx_d;
            s3_v_q    <= s3_v_d;
            s3_data_q <= s3_data_d;
            s3_idx_q  <= s3_idx_d;
            in_cnt_q  <= in_cnt_d;
        end
    end

`ifdef PWM_RANGE_CHECK_EN
    logic err_range_q, err_range_d;

    always_comb begin
        err_range_d = err_range_q;
        if (in_xfer && ((in_a >= Q) || (in_b >= Q))) begin
            err_range_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_range_q <= 1'b0;
        end else begin
            err_range_q <= err_range_d;
        end
    end

    assign err_range = err_range_q;
`else
    assign err_range = 1'b0;
`endif

    assign in_ready  = en;
    assign out_valid = s3_v_q;
    assign out_data  = s3_data_q;
    assign out_idx   = s3_idx_q;
    assign out_last  = s3_v_q && (s3_idx_q == IDX_W'(N - 1));
    assign busy      = s1_v_q | s2_v_q | s3_v_q;

endmodule

// File: tb/tb_pointwise_modmul_pipe.sv
// Directed self-checking bench for pointwise_modmul_pipe (WIDTH=16, N=16, Q=7681).
// A small reference pipeline holds hand-computed residues and tracks valid, index and stall behaviour.
`timescale 1ns/1ps
module tb_pointwise_modmul_pipe;

    localparam logic [15:0] Q = 16'h1e01;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy, err_range;
    logic [15:0] in_a, in_b, out_data;
    logic [3:0]  out_idx;

    int checks = 0;
    int errors = 0;

    // Reference pipeline: entry 2 is what the outputs should show.
    logic        m_v[3];
    logic [15:0] m_d[3];
    logic [3:0]  m_i[3];
    logic [3:0]  m_cnt;
    logic        m_err;

    pointwise_modmul_pipe #(.WIDTH(16), .N(16), .Q(16'h1e01)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
            m_i[i] = '0;
        end
        m_cnt = '0;
        m_err = 1'b0;
    endtask

    // Called at a negedge; drives one cycle of input, advances the model, returns at the next negedge.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, output logic acc);
        logic en;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        en       = !(m_v[2] && !out_ready);
        acc      = v && en;
        @(posedge clk);
        if (en) begin
            m_v[2] = m_v[1]; m_d[2] = m_d[1]; m_i[2] = m_i[1];
            m_v[1] = m_v[0]; m_d[1] = m_d[0]; m_i[1] = m_i[0];
            m_v[0] = v;      m_d[0] = res;    m_i[0] = m_cnt;
            if (v) m_cnt++;
        end
`ifdef PWM_RANGE_CHECK_EN
        if (acc && ((a >= Q) || (b >= Q))) m_err = 1'b1;
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic acc;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1 rst    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
        checks++; if ({out_last, busy, err_range} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {out_last, busy, err_range}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst = 1'b1;
        // Fill the pipe mid-frame, then reset asynchronously between edges.
        step(1'b1, 16'd5, 16'd5, 16'd25, acc);
        step(1'b1, 16'd6, 16'd6, 16'd36, acc);
        step(1'b1, 16'd7, 16'd7, 16'd49, acc);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midstream_busy got %b want 1", busy); end
        checks++; if (out_data !== 16'd25) begin errors++; $display("FAIL midstream_data got %0d want 25", out_data); end
        #2 rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if ({out_valid, out_last, busy} !== 3'b000) begin errors++; $display("FAIL async_reset_flags got %b want 000", {out_valid, out_last, busy}); end
        checks++; if (out_data !== 16'd0 || out_idx !== 4'd0) begin errors++; $display("FAIL async_reset_data got %0d/%0d want 0/0", out_data, out_idx); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step(j == 0, 16'd2, 16'd3, 16'd6, acc);
            checks++; if (out_valid !== m_v[2]) begin errors++; $display("FAIL post_reset_valid step %0d got %b want %b", j, out_valid, m_v[2]); end
            if (m_v[2]) begin
                checks++; if (out_data !== m_d[2] || out_idx !== m_i[2]) begin errors++; $display("FAIL post_reset_data got %0d idx %0d want %0d idx %0d", out_data, out_idx, m_d[2], m_i[2]); end
            end
        end
    endtask

    task automatic test_arith();
        logic [15:0] va[6] = '{16'd2, 16'd100, 16'd7680, 16'd0,    16'd7681, 16'd65535};
        logic [15:0] vb[6] = '{16'd3, 16'd100, 16'd7680, 16'd7680, 16'd5,    16'd65535};
        logic [15:0] vr[6] = '{16'd6, 16'd2319, 16'd1,   16'd0,    16'd0,    16'd5075};
        logic acc;
        out_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            if (j < 6) step(1'b1, va[j], vb[j], vr[j], acc);
            else       step(1'b0, 16'd0, 16'd0, 16'd0, acc);
            checks++; if (out_valid !== m_v[2]) begin errors++; $display("FAIL arith_valid step %0d got %b want %b", j, out_valid, m_v[2]); end
            if (m_v[2]) begin
                checks++; if (out_data !== m_d[2]) begin errors++; $display("FAIL arith_data step %0d got %0d want %0d", j, out_data, m_d[2]); end
                checks++; if (out_idx !== m_i[2]) begin errors++; $display("FAIL arith_idx step %0d got %0d want %0d", j, out_idx, m_i[2]); end
            end
            checks++; if (err_range !== m_err) begin errors++; $display("FAIL arith_err_range step %0d got %b want %b", j, err_range, m_err); end
        end
    endtask

    task automatic test_frame();
        logic acc;
        int   last_cnt = 0;
        do_reset();
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL frame_err_cleared got %b want 0", err_range); end
        for (int j = 0; j < 20; j++) begin
            if (j < 17) step(1'b1, 16'(j + 1), 16'd3, 16'(3 * (j + 1)), acc);
            else        step(1'b0, 16'd0, 16'd0, 16'd0, acc);
            checks++; if (out_valid !== m_v[2]) begin errors++; $display("FAIL frame_valid step %0d got %b want %b", j, out_valid, m_v[2]); end
            checks++; if (out_last !== (m_v[2] && m_i[2] == 4'd15)) begin errors++; $display("FAIL frame_last step %0d got %b want %b", j, out_last, m_v[2] && m_i[2] == 4'd15); end
            if (m_v[2]) begin
                checks++; if (out_idx !== m_i[2] || out_data !== m_d[2]) begin errors++; $display("FAIL frame_idx_data step %0d got %0d/%0d want %0d/%0d", j, out_idx, out_data, m_i[2], m_d[2]); end
            end
            if (out_last) last_cnt++;
        end
        checks++; if (last_cnt != 1) begin errors++; $display("FAIL frame_last_count got %0d want 1", last_cnt); end
    endtask

    task automatic test_stall();
        logic acc;
        int   k = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            #1;
            checks++; if (in_ready !== !(m_v[2] && !out_ready)) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b want %b", cyc, in_ready, !(m_v[2] && !out_ready)); end
            #1;
            step(k < 6, 16'(k + 10), 16'd2, 16'(2 * (k + 10)), acc);
            if (acc) k++;
            checks++; if (out_valid !== m_v[2]) begin errors++; $display("FAIL stall_valid cyc %0d got %b want %b", cyc, out_valid, m_v[2]); end
            if (m_v[2]) begin
                checks++; if (out_data !== m_d[2] || out_idx !== m_i[2]) begin errors++; $display("FAIL stall_data cyc %0d got %0d/%0d want %0d/%0d", cyc, out_data, out_idx, m_d[2], m_i[2]); end
            end
        end
        out_ready = 1'b1;
        checks++; if (k != 6 || busy !== 1'b0) begin errors++; $display("FAIL stall_drain accepted %0d busy %b want 6 0", k, busy); end
    endtask

    task automatic test_bubbles();
        logic       acc;
        logic       pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] exp_ov = 8'b0001_0100;   // bit j: out_valid after step j
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) step(pat[j], 16'(9 + j), 16'(9 + j), 16'((9 + j) * (9 + j)), acc);
            else       step(1'b0, 16'd0, 16'd0, 16'd0, acc);
            checks++; if (out_valid !== exp_ov[j]) begin errors++; $display("FAIL bubble_valid step %0d got %b want %b", j, out_valid, exp_ov[j]); end
            if (exp_ov[j]) begin
                checks++; if (out_data !== m_d[2]) begin errors++; $display("FAIL bubble_data step %0d got %0d want %0d", j, out_data, m_d[2]); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bubble_busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_frame();
        test_stall();
        test_bubbles();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
